hbif_rsp_tx: RTL and testbench

Response-side frame encoder and UART transmitter for the HBIF host bus interface. Accepts one completed bus response per handshake and serializes it onto `uart_tx_o` as an HBIF response frame: sync byte, status byte, optional data bytes and optional checksum. It is the transmit counterpart of the command receiver inside `tthbif` and drives the pin routed to `uio_out[4]`.

---
 rtl/hbif_pkg.sv | 29 ++
 rtl/hbif_uart_tx.sv | 62 ++++++
 rtl/hbif_rsp_tx.sv | 148 ++++++++++++++
 tb/tb_hbif_rsp_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hbif_pkg.sv
// Shared HBIF definitions: sync byte, status bit positions, frame FSM states.
package hbif_pkg;

  localparam logic [7:0] HBIF_SYNC_BYTE = 8'hA5;
  localparam int         HBIF_ST_ERR    = 0;
  localparam int         HBIF_ST_WR     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CHK
  } frame_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_ACTIVE
  } uart_state_e;

  function automatic logic [7:0] hbif_status(input logic wr, input logic err);
    logic [7:0] s;
    s              = '0;
    s[HBIF_ST_WR]  = wr;
    s[HBIF_ST_ERR] = err;
    return s;
  endfunction

endpackage

// File: rtl/hbif_uart_tx.sv
// 8N1 byte serializer, LSB first; a byte offered in the last cycle of a stop
// bit is taken immediately so consecutive bytes leave with no idle gap.
module hbif_uart_tx
  import hbif_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e   state;
  logic [8:0]    shift_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cyc_q;
  logic          tx_q;
  logic          bit_end;
  logic          last;

  assign bit_end      = (cyc_q == CW'(CLKS_PER_BIT - 1));
  assign last         = (state == TX_ACTIVE) && (bit_q == 4'd9) && bit_end;
  assign byte_ready_o = (state == TX_IDLE) || last;
  assign tx_o         = tx_q;

  // bit_q: 0 = start, 1..8 = data, 9 = stop; shift_q holds the bits still to go
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= TX_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= 1'b1;
    end else if (byte_valid_i && byte_ready_o) begin
      state   <= TX_ACTIVE;
      shift_q <= {1'b1, byte_i};
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= 1'b0;
    end else if (state == TX_ACTIVE) begin
      if (bit_end) begin
        cyc_q <= '0;
        if (bit_q == 4'd9) begin
          state <= TX_IDLE;
          tx_q  <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hbif_rsp_tx.sv
// HBIF response frame encoder: SYNC, STATUS, read data, optional checksum.
// Checksum byte and accumulator are built only with HBIF_RSP_CHKSUM_EN.
module hbif_rsp_tx
  import hbif_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BYTES   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  input  logic                    rsp_err_i,
  input  logic                    rsp_write_i,
  input  logic [8*DATA_BYTES-1:0] rsp_data_i,
  output logic                    uart_tx_o,
  output logic                    busy_o
);

  localparam int CW = $clog2(DATA_BYTES + 1);

  frame_state_e            state;
  logic                    busy_q;
  logic [7:0]              status_q;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [CW-1:0]           left_q;
`ifdef HBIF_RSP_CHKSUM_EN
  logic [7:0]              sum_q;
`endif
  logic                    accept;
  logic                    byte_valid;
  logic                    byte_ready;
  logic [7:0]              byte_d;

  // Valid/ready: a response transfers on a rising edge where rsp_valid_i and
  // rsp_ready_o are both high; valid is held upstream until that edge.
  assign rsp_ready_o = (state == ST_IDLE) && en_i;
  assign accept      = rsp_valid_i && rsp_ready_o;
  assign busy_o      = busy_q;

  // SYNC goes to the serializer on the handshake edge itself so the start bit
  // appears one cycle after acceptance.
  always_comb begin
    byte_valid = 1'b0;
    byte_d     = HBIF_SYNC_BYTE;
    unique case (state)
      ST_IDLE: begin
        byte_valid = accept;
        byte_d     = HBIF_SYNC_BYTE;
      end
      ST_SYNC: begin
        byte_valid = 1'b1;
        byte_d     = status_q;
      end
      ST_STATUS, ST_DATA: begin
        if (left_q != '0) begin
          byte_valid = 1'b1;
          byte_d     = data_q[7:0];
        end
`ifdef HBIF_RSP_CHKSUM_EN
        else begin
          byte_valid = 1'b1;
          byte_d     = 8'd0 - sum_q;
        end
`endif
      end
      default: begin
        byte_valid = 1'b0;
        byte_d     = HBIF_SYNC_BYTE;
      end
    endcase
  end

  // state names the byte currently on the line; advance when the serializer
  // takes the next byte or finishes the last stop bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      status_q <= '0;
      data_q   <= '0;
      left_q   <= '0;
`ifdef HBIF_RSP_CHKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SYNC;
            busy_q   <= 1'b1;
            status_q <= hbif_status(rsp_write_i, rsp_err_i);
            data_q   <= rsp_data_i;
            left_q   <= (!rsp_write_i && !rsp_err_i) ? CW'(DATA_BYTES) : '0;
`ifdef HBIF_RSP_CHKSUM_EN
            sum_q    <= hbif_status(rsp_write_i, rsp_err_i);
`endif
          end
        end
        ST_SYNC: begin
          if (byte_ready) state <= ST_STATUS;
        end
        ST_STATUS, ST_DATA: begin
          if (byte_ready) begin
            if (left_q != '0) begin
              state  <= ST_DATA;
              data_q <= data_q >> 8;
              left_q <= left_q - CW'(1);
`ifdef HBIF_RSP_CHKSUM_EN
              sum_q  <= sum_q + data_q[7:0];
`endif
            end else begin
`ifdef HBIF_RSP_CHKSUM_EN
              state  <= ST_CHK;
`else
              state  <= ST_IDLE;
              busy_q <= 1'b0;
`endif
            end
          end
        end
        ST_CHK: begin
          if (byte_ready) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  hbif_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .byte_valid_i(byte_valid),
    .byte_i      (byte_d),
    .byte_ready_o(byte_ready),
    .tx_o        (uart_tx_o)
  );

endmodule

// File: tb/tb_hbif_rsp_tx.sv
// Bench for hbif_rsp_tx: table of response frames plus hand-written sequences
// for back-to-back, enable drop and mid-frame reset.
module tb_hbif_rsp_tx;

  localparam int CPB = 4;
  localparam int DB  = 4;
`ifdef HBIF_RSP_CHKSUM_EN
  localparam int NO_CHK = 0;
`else
  localparam int NO_CHK = 1;
`endif

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] data;
    logic [55:0] frame;   // byte 0 (SYNC) in [7:0], checksum byte last
    int          n_full;  // byte count including checksum
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic          rsp_write;
  logic [31:0]   rsp_data;
  logic          uart_tx;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q[$];
  vec_t          vecs[6];

  hbif_rsp_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BYTES  (DB)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .rsp_valid_i(rsp_valid),
    .rsp_ready_o(rsp_ready),
    .rsp_err_i  (rsp_err),
    .rsp_write_i(rsp_write),
    .rsp_data_i (rsp_data),
    .uart_tx_o  (uart_tx),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < v.n_full - NO_CHK; i++) exp_q.push_back(v.frame[8*i +: 8]);
  endtask

  task automatic drive(input vec_t v);
    rsp_err   = v.err;
    rsp_write = v.wr;
    rsp_data  = v.data;
    rsp_valid = 1'b1;
  endtask

  // Waits (bounded) for ready at a falling edge, lets the handshake edge pass,
  // then withdraws valid and scrambles the payload to prove it was captured.
  task automatic send(input vec_t v);
    int t;
    t = 0;
    drive(v);
    while (rsp_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    rsp_data  = $urandom;
    rsp_err   = 1'($urandom_range(0, 1));
    rsp_write = 1'($urandom_range(0, 1));
  endtask

  // Called just after the handshake edge: every cycle of the frame is checked
  // against the expected 8N1 waveform, each byte is decoded mid-bit and
  // scored, then the single idle cycle after the last stop bit is checked.
  task automatic check_frame(input logic [55:0] fr, input int n);
    int         cyc;
    int         bad;
    int         busy_bad;
    int         rdy_bad;
    logic [9:0] bits;
    logic [7:0] got;
    cyc      = 0;
    bad      = -1;
    busy_bad = -1;
    rdy_bad  = -1;
    for (int by = 0; by < n; by++) begin
      bits = {1'b1, fr[8*by +: 8], 1'b0};
      got  = '0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          if (uart_tx !== bits[bi] && bad < 0) bad = cyc;
          if (busy !== 1'b1 && busy_bad < 0) busy_bad = cyc;
          if (rsp_ready !== 1'b0 && rdy_bad < 0) rdy_bad = cyc;
          if (c == CPB / 2 && bi >= 1 && bi <= 8) got[bi-1] = uart_tx;
          cyc++;
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=%0h required=none", got);
      end else begin
        chk("frame_byte", 64'(got), 64'(exp_q.pop_front()));
      end
    end
    chk("wave_first_bad_cycle", 64'(bad), 64'(-1));
    chk("busy_low_in_frame_cycle", 64'(busy_bad), 64'(-1));
    chk("ready_high_in_frame_cycle", 64'(rdy_bad), 64'(-1));
    @(negedge clk);
    chk("tx_idle_after_frame", 64'(uart_tx), 64'd1);
    chk("busy_after_frame", 64'(busy), 64'd0);
    chk("ready_after_frame", 64'(rsp_ready), 64'(en));
  endtask

  initial begin
    vecs[0] = '{err: 1'b0, wr: 1'b0, data: 32'h44332211, frame: 56'h56_44_33_22_11_00_A5, n_full: 7};
    vecs[1] = '{err: 1'b0, wr: 1'b1, data: 32'h12345678, frame: 56'h00_00_00_00_FE_02_A5, n_full: 3};
    vecs[2] = '{err: 1'b1, wr: 1'b0, data: 32'h44332211, frame: 56'h00_00_00_00_FF_01_A5, n_full: 3};
    vecs[3] = '{err: 1'b1, wr: 1'b1, data: 32'h0, frame: 56'h00_00_00_00_FD_03_A5, n_full: 3};
    vecs[4] = '{err: 1'b0, wr: 1'b0, data: 32'hDEADBEEF, frame: 56'hC8_DE_AD_BE_EF_00_A5, n_full: 7};
    vecs[5] = '{err: 1'b1, wr: 1'b0, data: 32'hFFFFFFFF, frame: 56'h00_00_00_00_FF_01_A5, n_full: 3};

    // clock/reset
    rst_n     = 1'b0;
    en        = 1'b1;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_write = 1'b0;
    rsp_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(uart_tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready_en1", 64'(rsp_ready), 64'd1);
    en = 1'b0;
    #1;
    chk("reset_ready_en0", 64'(rsp_ready), 64'd0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i]);
      send(vecs[i]);
      check_frame(vecs[i].frame, vecs[i].n_full - NO_CHK);
    end

    // back-to-back: second response held valid during the first frame
    push_exp(vecs[1]);
    send(vecs[1]);
    drive(vecs[2]);
    check_frame(vecs[1].frame, vecs[1].n_full - NO_CHK);
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    push_exp(vecs[2]);
    check_frame(vecs[2].frame, vecs[2].n_full - NO_CHK);

    // enable dropped during the DATA phase
    push_exp(vecs[4]);
    send(vecs[4]);
    fork
      check_frame(vecs[4].frame, vecs[4].n_full - NO_CHK);
      begin
        repeat (10 * CPB * 3 + 2) @(negedge clk);
        en = 1'b0;
      end
    join
    drive(vecs[0]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ready_while_disabled", 64'(rsp_ready), 64'd0);
      chk("idle_while_disabled", 64'({busy, uart_tx}), 64'b01);
    end
    en = 1'b1;
    push_exp(vecs[0]);
    send(vecs[0]);
    check_frame(vecs[0].frame, vecs[0].n_full - NO_CHK);

    // asynchronous reset in the middle of the STATUS byte
    send(vecs[1]);
    repeat (10 * CPB + 6) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", 64'(uart_tx), 64'd1);
    chk("async_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("ready_after_reset", 64'(rsp_ready), 64'd1);
    push_exp(vecs[0]);
    send(vecs[0]);
    check_frame(vecs[0].frame, vecs[0].n_full - NO_CHK);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
